// File: rtl/lock_code_file.sv
// lock_code_file: NUM_REGS x DATA_W code store with one write port, two
// combinational read ports and a sequential digit-compare engine.
// Optional feature: define LOCK_FILE_LOCKOUT_EN to add the failed-attempt
// counter and lockout; without it lockout is tied low.
module lock_code_file #(
  parameter int DATA_W    = 5,
  parameter int NUM_REGS  = 4,
  parameter int CODE_LEN  = 3,
  parameter int MAX_FAILS = 3,
  localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic [SEL_W-1:0]  regSel,
  input  logic [DATA_W-1:0] regIn,
  input  logic [SEL_W-1:0]  outSel0,
  input  logic [SEL_W-1:0]  outSel1,
  output logic [DATA_W-1:0] opRead0,
  output logic [DATA_W-1:0] opRead1,
  input  logic              cmpStart,
  input  logic              cmpAbort,
  input  logic              digitValid,
  input  logic [DATA_W-1:0] digitIn,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              lockout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // One wider than the select so that every select value can be compared
  // against NUM_REGS even when NUM_REGS is a power of two.
  localparam logic [SEL_W:0]   NUM_REGS_C = (SEL_W+1)'(NUM_REGS);
  localparam logic [SEL_W-1:0] LAST_IDX_C = SEL_W'(CODE_LEN - 1);

  // True when a select value addresses an existing entry.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    sel_in_range = ({1'b0, sel} < NUM_REGS_C);
  endfunction

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] rd0_s;
  logic [DATA_W-1:0] rd1_s;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SEL_W-1:0]  idx_r;
  logic [SEL_W-1:0]  idx_nxt_s;
  logic              mism_r;
  logic              mism_nxt_s;
  logic              match_r;
  logic              match_nxt_s;
  logic              busy_r;
  logic              done_r;
  logic              enter_done_s;
  logic              digit_miss_s;
  logic              wr_en_s;
  logic              lockout_s;

  // Writes land only while idle and only for an existing entry.
  always_comb begin
    wr_en_s = 1'b0;
    if (WR && (state_r == ST_IDLE) && sel_in_range(regSel)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Code store: cleared by reset, updated by the single write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[regSel] <= regIn;
    end
  end

  // Read port 0: out-of-range select reads as zero, no write bypass.
  always_comb begin
    rd0_s = {DATA_W{1'b0}};
    if (sel_in_range(outSel0)) begin
      rd0_s = regs_r[outSel0];
    end else begin
      rd0_s = {DATA_W{1'b0}};
    end
  end

  // Read port 1: same behaviour as port 0.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    if (sel_in_range(outSel1)) begin
      rd1_s = regs_r[outSel1];
    end else begin
      rd1_s = {DATA_W{1'b0}};
    end
  end

  assign opRead0 = rd0_s;
  assign opRead1 = rd1_s;

  // Accumulated mismatch including the digit presented this cycle.
  always_comb begin
    digit_miss_s = mism_r | (digitIn != regs_r[idx_r]);
  end

  // Compare FSM next-state logic; abort outranks a digit in the same cycle.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    mism_nxt_s   = mism_r;
    match_nxt_s  = match_r;
    enter_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmpStart && !lockout_s) begin
          state_nxt_s = ST_COMPARE;
          idx_nxt_s   = {SEL_W{1'b0}};
          mism_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (cmpAbort) begin
          state_nxt_s = ST_IDLE;
        end else if (digitValid) begin
          mism_nxt_s = digit_miss_s;
          if (idx_r == LAST_IDX_C) begin
            state_nxt_s  = ST_DONE;
            match_nxt_s  = ~digit_miss_s;
            enter_done_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + SEL_W'(1);
          end
        end else begin
          state_nxt_s = ST_COMPARE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Compare FSM state and result registers; match is loaded on entry to
  // DONE so it is already valid during the done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      idx_r   <= {SEL_W{1'b0}};
      mism_r  <= 1'b0;
      match_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      mism_r  <= mism_nxt_s;
      match_r <= match_nxt_s;
      busy_r  <= (state_nxt_s == ST_COMPARE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef LOCK_FILE_LOCKOUT_EN
  localparam int                FAIL_W      = $clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0] MAX_FAILS_C = FAIL_W'(MAX_FAILS);

  logic [FAIL_W-1:0] fail_cnt_r;
  logic [FAIL_W-1:0] fail_cnt_nxt_s;
  logic              lockout_r;

  // Consecutive-failure count: saturates on misses, clears on a match.
  always_comb begin
    fail_cnt_nxt_s = fail_cnt_r;
    if (enter_done_s) begin
      if (match_nxt_s) begin
        fail_cnt_nxt_s = {FAIL_W{1'b0}};
      end else if (fail_cnt_r != MAX_FAILS_C) begin
        fail_cnt_nxt_s = fail_cnt_r + FAIL_W'(1);
      end else begin
        fail_cnt_nxt_s = fail_cnt_r;
      end
    end else begin
      fail_cnt_nxt_s = fail_cnt_r;
    end
  end

  // Failure counter and registered lockout flag; only reset releases it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_cnt_r <= {FAIL_W{1'b0}};
      lockout_r  <= 1'b0;
    end else begin
      fail_cnt_r <= fail_cnt_nxt_s;
      lockout_r  <= (fail_cnt_nxt_s == MAX_FAILS_C);
    end
  end

  assign lockout_s = lockout_r;
`else
  assign lockout_s = 1'b0;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign match   = match_r;
  assign lockout = lockout_s;

endmodule
